fp16_stream_acc: RTL and testbench



---
 rtl/fp16_stream_acc.sv | 215 +++++++++++++++++++++
 tb/tb_fp16_stream_acc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_stream_acc.sv
// Streaming float16 sum-reduction: fp16 -> 43-bit Q18.24 fixed, saturating accumulate,
// then round back to fp16 per vector. Fixed 5-stage pipeline, no backpressure.
module fp16_stream_acc #(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    output logic [15:0]   out_data,
    output logic          out_sat,
    output logic [CW-1:0] out_count
);

    localparam logic [42:0] PosMax = 43'h3FF_FFFF_FFFF;
    localparam logic [42:0] NegMax = 43'h400_0000_0000;

    // S1: input register
    logic        s1_valid_q, s1_valid_d;
    logic        s1_last_q, s1_last_d;
    logic [15:0] s1_data_q, s1_data_d;

    // S2: converted term
    logic        s2_valid_q, s2_valid_d;
    logic        s2_last_q, s2_last_d;
    logic        s2_inf_q, s2_inf_d;
    logic [42:0] s2_term_q, s2_term_d;

    // S3: accumulator state; acc/cnt/sat also serve as the closed-vector result
    logic [42:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic          closed_q, closed_d;
    logic          s3_valid_q, s3_valid_d;

    // S4: normalised magnitude
    logic          s4_valid_q, s4_valid_d;
    logic          s4_sign_q, s4_sign_d;
    logic          s4_zero_q, s4_zero_d;
    logic [5:0]    s4_lead_q, s4_lead_d;
    logic [10:0]   s4_sig_q, s4_sig_d;
    logic          s4_guard_q, s4_guard_d;
    logic [CW-1:0] s4_cnt_q, s4_cnt_d;
    logic          s4_sat_q, s4_sat_d;

    // S5: registered outputs
    logic          out_valid_q, out_valid_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_sat_q, out_sat_d;
    logic [CW-1:0] out_count_q, out_count_d;

    always_comb begin
        s1_valid_d = in_valid;
        s1_last_d  = in_last;
        s1_data_d  = in_data;
    end

    logic [4:0]  f_exp;
    logic [42:0] f_mag;

    always_comb begin
        f_exp      = s1_data_q[14:10];
        f_mag      = {32'd0, 1'b1, s1_data_q[9:0]} << (f_exp - 5'd1);
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_inf_d   = 1'b0;
        s2_term_d  = '0;
        if (f_exp == 5'd31) begin
            s2_inf_d  = 1'b1;
            s2_term_d = s1_data_q[15] ? NegMax : PosMax;
        end else if (f_exp != 5'd0) begin
            s2_term_d = s1_data_q[15] ? (~f_mag + 43'd1) : f_mag;
        end
    end

    logic [42:0]   base_acc;
    logic [42:0]   sum;
    logic [CW-1:0] base_cnt;
    logic          base_sat;
    logic          ovf;

    always_comb begin
        base_acc = closed_q ? '0 : acc_q;
        base_cnt = closed_q ? '0 : cnt_q;
        base_sat = closed_q ? 1'b0 : sat_q;
        sum      = base_acc + s2_term_q;
        ovf      = (base_acc[42] == s2_term_q[42]) && (sum[42] != base_acc[42]);

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        closed_d   = closed_q;
        s3_valid_d = 1'b0;
        if (s2_valid_q) begin
            if (ovf) begin
                acc_d = base_acc[42] ? NegMax : PosMax;
            end else begin
                acc_d = sum;
            end
            cnt_d      = base_cnt + CW'(1);
            sat_d      = base_sat | ovf | s2_inf_q;
            closed_d   = s2_last_q || (cnt_d == CW'(MAX_LEN));
            s3_valid_d = closed_d;
        end
    end

    logic [42:0] mag;
    logic [5:0]  lead;

    always_comb begin
        mag  = acc_q[42] ? (~acc_q + 43'd1) : acc_q;
        lead = '0;
        for (int i = 0; i < 43; i++) begin
            if (mag[i]) begin
                lead = 6'(i);
            end
        end
        s4_valid_d = s3_valid_q;
        s4_sign_d  = acc_q[42];
        s4_zero_d  = (mag == '0);
        s4_lead_d  = lead;
        // Leading one lands on bit 42; keep 11 significand bits plus the guard bit.
        {s4_sig_d, s4_guard_d} = 12'((mag << (6'd42 - lead)) >> 31);
        s4_cnt_d   = cnt_q;
        s4_sat_d   = sat_q;
    end

    logic [11:0] rsum;
    logic [6:0]  res_exp;

    always_comb begin
        out_valid_d = s4_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        rsum        = {1'b0, s4_sig_q} + {11'd0, s4_guard_q};
        // rsum[11:10] is 2'b01 normally and 2'b10 after a rounding carry.
        res_exp     = 7'(s4_lead_q) + 7'(rsum[11:10]) - 7'd10;
        if (s4_valid_q) begin
            out_count_d = s4_cnt_q;
            out_sat_d   = s4_sat_q;
            if (s4_zero_q || (s4_lead_q <= 6'd9)) begin
                out_data_d = 16'h0000;
            end else if (res_exp >= 7'd31) begin
                out_data_d = {s4_sign_q, 15'h7BFF};
                out_sat_d  = 1'b1;
            end else begin
                out_data_d = {s4_sign_q, res_exp[4:0], rsum[9:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_term_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            closed_q    <= 1'b1;
            s3_valid_q  <= 1'b0;
            s4_valid_q  <= 1'b0;
            s4_sign_q   <= 1'b0;
            s4_zero_q   <= 1'b1;
            s4_lead_q   <= '0;
            s4_sig_q    <= '0;
            s4_guard_q  <= 1'b0;
            s4_cnt_q    <= '0;
            s4_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_inf_q    <= s2_inf_d;
            s2_term_q   <= s2_term_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            closed_q    <= closed_d;
            s3_valid_q  <= s3_valid_d;
            s4_valid_q  <= s4_valid_d;
            s4_sign_q   <= s4_sign_d;
            s4_zero_q   <= s4_zero_d;
            s4_lead_q   <= s4_lead_d;
            s4_sig_q    <= s4_sig_d;
            s4_guard_q  <= s4_guard_d;
            s4_cnt_q    <= s4_cnt_d;
            s4_sat_q    <= s4_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_fp16_stream_acc.sv
// Scoreboard bench for fp16_stream_acc: a default instance and a MAX_LEN=4 instance.
module tb_fp16_stream_acc;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        in_valid, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_sat;
    logic [15:0] out_data;
    logic [8:0]  out_count;

    logic        in4_valid, in4_last;
    logic [15:0] in4_data;
    logic        out4_valid, out4_sat;
    logic [15:0] out4_data;
    logic [2:0]  out4_count;

    fp16_stream_acc #(.MAX_LEN(256)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    fp16_stream_acc #(.MAX_LEN(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in4_valid),
        .in_last   (in4_last),
        .in_data   (in4_data),
        .out_valid (out4_valid),
        .out_data  (out4_data),
        .out_sat   (out4_sat),
        .out_count (out4_count)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        int          count;
        int unsigned due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q4[$];
    exp_t        m0, m4;
    int          total = 0;
    int          bad = 0;
    int unsigned last_edge = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious0: got out_valid=1 data=%0h want no output", out_data);
            end else begin
                m0 = q0.pop_front();
                check("data0", out_data, m0.data);
                check("sat0", out_sat, m0.sat);
                check("count0", out_count, m0.count);
                check("latency0", edge_cnt, m0.due);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && out4_valid) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious4: got out_valid=1 data=%0h want no output", out4_data);
            end else begin
                m4 = q4.pop_front();
                check("data4", out4_data, m4.data);
                check("sat4", out4_sat, m4.sat);
                check("count4", out4_count, m4.count);
                check("latency4", edge_cnt, m4.due);
            end
        end
    end

    task automatic send(input bit sel, input logic [15:0] d, input bit last);
        if (sel) begin
            in4_valid = 1'b1;
            in4_last  = last;
            in4_data  = d;
        end else begin
            in_valid = 1'b1;
            in_last  = last;
            in_data  = d;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in4_valid = 1'b0;
        in4_last  = 1'b0;
        last_edge = edge_cnt;
    endtask

    task automatic expect_res(input bit sel, input logic [15:0] d, input bit s, input int c);
        exp_t e;
        e.data  = d;
        e.sat   = s;
        e.count = c;
        e.due   = last_edge + 4;
        if (sel) q4.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic idle(input int n, input bit last);
        in_valid  = 1'b0;
        in4_valid = 1'b0;
        in_last   = last;
        in4_last  = last;
        repeat (n) @(posedge clk);
        #1;
        in_last  = 1'b0;
        in4_last = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        in4_valid = 1'b0;
        in4_last  = 1'b0;
        in4_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 16'h0000);
        check("rst_sat", out_sat, 1'b0);
        check("rst_count", out_count, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back vectors, no bubbles between closes
        send(0, 16'h3C00, 0); send(0, 16'h4000, 1); expect_res(0, 16'h4200, 0, 2);
        send(0, 16'h3C00, 0); send(0, 16'hBC00, 1); expect_res(0, 16'h0000, 0, 2);
        send(0, 16'h0001, 0); send(0, 16'h3C00, 1); expect_res(0, 16'h3C00, 0, 2);
        send(0, 16'h3C00, 0); send(0, 16'h1000, 1); expect_res(0, 16'h3C01, 0, 2);
        for (int i = 0; i < 5; i++) send(0, 16'h7BFF, i == 4);
        expect_res(0, 16'h7BFF, 1, 5);
        send(0, 16'h4000, 1); expect_res(0, 16'h4000, 0, 1);
        send(0, 16'hBC00, 1); expect_res(0, 16'hBC00, 0, 1);
        send(0, 16'hC000, 1); expect_res(0, 16'hC000, 0, 1);
        send(0, 16'h7C00, 1); expect_res(0, 16'h7BFF, 1, 1);
        send(0, 16'hFC00, 1); expect_res(0, 16'hFBFF, 1, 1);

        // Idle cycles with in_last high must not close anything
        idle(10, 1);

        // Reset mid-vector discards the partial sum
        send(0, 16'h4000, 0);
        send(0, 16'h4000, 0);
        reset_n = 1'b0;
        #3;
        check("midrst_data", out_data, 16'h0000);
        check("midrst_count", out_count, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 16'h3C00, 1); expect_res(0, 16'h3C00, 0, 1);

        // Auto-close at MAX_LEN=4
        for (int i = 0; i < 6; i++) begin
            send(1, 16'h3C00, 0);
            if (i == 3) expect_res(1, 16'h4400, 0, 4);
        end
        idle(1, 0);
        send(1, 16'h3C00, 1); expect_res(1, 16'h4200, 0, 3);

        for (int i = 0; i < 50 && (q0.size() + q4.size()) != 0; i++) @(posedge clk);
        idle(6, 0);
        check("drain", q0.size() + q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
